// File: rtl/ms_uart_pkg.sv
// ---------------------------------------------------------------------------
// ms_uart_pkg
// Shared types and constants for the UART baud-rate controller slice.
//   ab_state_e       : baud controller FSM states
//   SYNC_FALL_EDGES  : falling edges on RX in a 0x55 sync character, counting
//                      the start bit (start, bit1, bit3, bit5, bit7)
//   SYNC_BITS_LOG2   : log2 of the bit times spanned by edge 1 .. edge 5 (8)
//   DEF_RST_UBRR     : default divisor after reset (9600 baud, 16 MHz, 16x)
// ---------------------------------------------------------------------------
package ms_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_MEASURE    = 3'd2,
        ST_CALC       = 3'd3,
        ST_APPLY      = 3'd4
    } ab_state_e;

    localparam int          SYNC_FALL_EDGES = 5;
    localparam int          SYNC_BITS_LOG2  = 3;
    localparam logic [15:0] DEF_RST_UBRR    = 16'd103;

endpackage

// File: rtl/ms_uart_ab_meas.sv
// ---------------------------------------------------------------------------
// ms_uart_ab_meas
// Auto-baud measurement datapath: RX falling-edge detector, saturating cycle
// counter and falling-edge counter.
// Ports:
//   CLK, RESETN : clock, synchronous active-low reset
//   rxd_i       : synchronised RX line (idle high)
//   clr_i       : hold counters at zero
//   arm_i       : waiting for the start bit; a falling edge restarts counting
//   en_i        : measuring; counter advances, falling edges are counted
//   start_o     : start-bit falling edge seen while armed
//   done_o      : last sync falling edge seen while measuring
//   ovf_o       : counter saturated while measuring
//   m_o         : measured cycle count (counter + 1), valid with done_o
// ---------------------------------------------------------------------------
module ms_uart_ab_meas
    import ms_uart_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             rxd_i,
    input  logic             clr_i,
    input  logic             arm_i,
    input  logic             en_i,
    output logic             start_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] m_o
);

    localparam int EDGE_W = $clog2(SYNC_FALL_EDGES + 1);

    logic              rxd_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              fall;

    assign fall    = rxd_q & ~rxd_i;
    assign start_o = arm_i & fall;
    // edge_q already holds the edges seen so far, so this edge is the last one
    assign done_o  = en_i & fall & (edge_q == EDGE_W'(SYNC_FALL_EDGES - 1));
    assign ovf_o   = en_i & (cnt_q == {CNT_W{1'b1}});
    // The sample on the final edge closes the span, hence the +1
    assign m_o     = cnt_q + CNT_W'(1);

    always_comb begin
        cnt_d  = cnt_q;
        edge_d = edge_q;
        if (clr_i) begin
            cnt_d  = '0;
            edge_d = '0;
        end else if (start_o) begin
            cnt_d  = '0;
            edge_d = EDGE_W'(1);
        end else if (en_i) begin
            if (!ovf_o) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (fall && (edge_q != EDGE_W'(SYNC_FALL_EDGES))) begin
                edge_d = edge_q + EDGE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rxd_q  <= 1'b1;
            cnt_q  <= '0;
            edge_q <= '0;
        end else begin
            rxd_q  <= rxd_i;
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/ms_uart_baud_ctrl.sv
// ---------------------------------------------------------------------------
// ms_uart_baud_ctrl
// Owns the UBRR divisor of the UART baud generator. UBRR changes either by a
// software write or by auto-baud (measuring a 0x55 sync character on RX).
// Every change is applied in one cycle together with a one-cycle BG_RST pulse
// so the generator restarts on the new divisor.
// Ports:
//   CLK, RESETN : clock, synchronous active-low reset
//   RXD_SYNC    : synchronised RX line (idle high)
//   CFG_WR      : one-cycle write strobe, CFG_WDATA is the new UBRR
//   CFG_ACK     : one-cycle pulse when a write is applied
//   AB_START    : one-cycle auto-baud request (only honoured in IDLE)
//   AB_ABORT    : cancel auto-baud while waiting/measuring
//   AB_BUSY     : auto-baud in progress
//   AB_DONE     : one-cycle pulse, auto-baud result applied
//   AB_ERR      : one-cycle pulse, auto-baud timeout or out-of-range result
//   UBRR        : divisor to the baud generator
//   BG_RST      : active-high reset to the baud generator
//   DBG_STATE   : current FSM state (ab_state_e encoding)
// Handshake: the strobes (CFG_WR, AB_START, AB_ABORT) are single-cycle
// requests with no ready; they are sampled only in the states that accept
// them and dropped otherwise. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ms_uart_baud_ctrl
    import ms_uart_pkg::*;
#(
    parameter logic [15:0] RST_UBRR = DEF_RST_UBRR,
    parameter int          OSR_LOG2 = 4,
    parameter int          CNT_W    = 24,
    parameter logic [15:0] MIN_UBRR = 16'd3
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        RXD_SYNC,
    input  logic        CFG_WR,
    input  logic [15:0] CFG_WDATA,
    output logic        CFG_ACK,
    input  logic        AB_START,
    input  logic        AB_ABORT,
    output logic        AB_BUSY,
    output logic        AB_DONE,
    output logic        AB_ERR,
    output logic [15:0] UBRR,
    output logic        BG_RST,
    output logic [2:0]  DBG_STATE
);

    localparam int SHIFT = SYNC_BITS_LOG2 + OSR_LOG2;

    ab_state_e        state_q, state_d;
    logic [15:0]      pend_q, pend_d;
    logic             src_auto_q, src_auto_d;
    logic [CNT_W-1:0] m_q, m_d;
    logic [15:0]      ubrr_q, ubrr_d;
    logic             bg_rst_q, bg_rst_d;
    logic             cfg_ack_q, cfg_ack_d;
    logic             ab_done_q, ab_done_d;
    logic             ab_err_q, ab_err_d;
    logic             ab_busy_q, ab_busy_d;

    logic             meas_start, meas_done, meas_ovf;
    logic [CNT_W-1:0] meas_m;
    logic [31:0]      calc_q;
    logic             calc_bad;
    logic [15:0]      calc_res;

    ms_uart_ab_meas #(
        .CNT_W (CNT_W)
    ) u_meas (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .rxd_i   (RXD_SYNC),
        .clr_i   (state_q == ST_IDLE),
        .arm_i   (state_q == ST_WAIT_START),
        .en_i    (state_q == ST_MEASURE),
        .start_o (meas_start),
        .done_o  (meas_done),
        .ovf_o   (meas_ovf),
        .m_o     (meas_m)
    );

    // M spans 8 bit times of OSR ticks each; divide out both, then UBRR = q-1.
    // Reject q-1 < MIN_UBRR (including q = 0) and q-1 > 16'hFFFF.
    assign calc_q   = 32'(m_q) >> SHIFT;
    assign calc_bad = (calc_q < (32'(MIN_UBRR) + 32'd1)) || (calc_q > 32'h0001_0000);
    // Low 16 bits suffice: in the accepted range q = 16'h10000 maps to FFFF
    assign calc_res = calc_q[15:0] - 16'd1;

    // State register
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the values captured along the way
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        src_auto_d = src_auto_q;
        m_d        = m_q;
        unique case (state_q)
            ST_IDLE: begin
                if (CFG_WR) begin
                    state_d    = ST_APPLY;
                    pend_d     = CFG_WDATA;
                    src_auto_d = 1'b0;
                end else if (AB_START) begin
                    state_d = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (AB_ABORT) begin
                    state_d = ST_IDLE;
                end else if (meas_start) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (AB_ABORT) begin
                    state_d = ST_IDLE;
                end else if (meas_done) begin
                    state_d = ST_CALC;
                    m_d     = meas_m;
                end else if (meas_ovf) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (calc_bad) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_APPLY;
                    pend_d     = calc_res;
                    src_auto_d = 1'b1;
                end
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs
    always_comb begin
        ubrr_d    = ubrr_q;
        bg_rst_d  = 1'b0;
        cfg_ack_d = 1'b0;
        ab_done_d = 1'b0;
        ab_err_d  = 1'b0;
        if (state_q == ST_APPLY) begin
            ubrr_d    = pend_q;
            bg_rst_d  = 1'b1;
            cfg_ack_d = ~src_auto_q;
            ab_done_d = src_auto_q;
        end
        if ((state_q == ST_MEASURE) && !AB_ABORT && !meas_done && meas_ovf) begin
            ab_err_d = 1'b1;
        end
        if ((state_q == ST_CALC) && calc_bad) begin
            ab_err_d = 1'b1;
        end
        // Derived from the next state so BUSY lines up with the state register
        ab_busy_d = (state_d == ST_WAIT_START) || (state_d == ST_MEASURE) ||
                    (state_d == ST_CALC) || ((state_d == ST_APPLY) && src_auto_d);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            pend_q     <= '0;
            src_auto_q <= 1'b0;
            m_q        <= '0;
            ubrr_q     <= RST_UBRR;
            bg_rst_q   <= 1'b1;
            cfg_ack_q  <= 1'b0;
            ab_done_q  <= 1'b0;
            ab_err_q   <= 1'b0;
            ab_busy_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            src_auto_q <= src_auto_d;
            m_q        <= m_d;
            ubrr_q     <= ubrr_d;
            bg_rst_q   <= bg_rst_d;
            cfg_ack_q  <= cfg_ack_d;
            ab_done_q  <= ab_done_d;
            ab_err_q   <= ab_err_d;
            ab_busy_q  <= ab_busy_d;
        end
    end

    assign UBRR      = ubrr_q;
    assign BG_RST    = bg_rst_q;
    assign CFG_ACK   = cfg_ack_q;
    assign AB_DONE   = ab_done_q;
    assign AB_ERR    = ab_err_q;
    assign AB_BUSY   = ab_busy_q;
    assign DBG_STATE = state_q;

endmodule
